xm_inst_encoder: RTL and testbench

- Converts field-level instruction requests into 16-bit X-Makina instruction words. It is the inverse of the instruction decoder.
- Expands a 16-bit immediate load into the shortest MOVL/MOVLZ/MOVLS/MOVH sequence.
- Buffers the encoded words in an output FIFO with valid/ready handshake.
- Used by debug/trap injection logic and boot stubs to feed the fetch path.

---
 rtl/xm_inst_encoder.sv | 189 ++++++++++++++++++
 tb/tb_xm_inst_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xm_inst_encoder.sv
// X-Makina instruction encoder: turns field-level requests into 16-bit instruction words
// and queues them in a first-word fall-through FIFO for the fetch path.
module xm_inst_encoder #(
    parameter int unsigned WORD  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     reqValid_i,
    output logic                     reqReady_o,
    input  logic [2:0]               reqKind_i,
    input  logic [3:0]               aluOp_i,
    input  logic                     constSel_i,
    input  logic                     byteOp_i,
    input  logic [2:0]               regAdrA_i,
    input  logic [2:0]               regAdrB_i,
    input  logic [2:0]               cond_i,
    input  logic [WORD-1:0]          value_i,
    output logic [WORD-1:0]          inst_o,
    output logic                     instValid_o,
    input  logic                     instReady_i,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [2:0] KIND_ALU = 3'd0;
    localparam logic [2:0] KIND_IMM = 3'd1;
    localparam logic [2:0] KIND_BL  = 3'd2;
    localparam logic [2:0] KIND_CB  = 3'd3;
    localparam logic [2:0] KIND_LDR = 3'd4;
    localparam logic [2:0] KIND_STR = 3'd5;

    typedef enum logic [0:0] {StIdle, StHigh} state_e;

    state_e            state_q, state_d;
    logic [WORD-1:0]   movh_q, movh_d;
    logic              err_q, err_d;

    logic [WORD-1:0]   enc_word;
    logic [WORD-1:0]   enc_movh;
    logic              enc_legal;
    logic              enc_split;

    logic              accept;
    logic              push;
    logic [WORD-1:0]   push_word;
    logic              pop;

    logic [WORD-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    // Field packing and legality; branch/memory offsets must be the sign extension
    // of the encoded field width.
    always_comb begin
        enc_word  = '0;
        enc_movh  = '0;
        enc_legal = 1'b0;
        enc_split = 1'b0;
        case (reqKind_i)
            KIND_ALU: begin
                enc_word  = {4'b0100, aluOp_i, constSel_i, byteOp_i, regAdrB_i, regAdrA_i};
                enc_legal = 1'b1;
            end
            KIND_IMM: begin
                enc_legal = 1'b1;
                enc_movh  = {3'b011, 2'b11, value_i[15:8], regAdrA_i};
                if (value_i[15:8] == 8'h00) begin
                    enc_word = {3'b011, 2'b01, value_i[7:0], regAdrA_i};
                end else if (value_i[15:8] == 8'hFF) begin
                    enc_word = {3'b011, 2'b10, value_i[7:0], regAdrA_i};
                end else begin
                    enc_word  = {3'b011, 2'b00, value_i[7:0], regAdrA_i};
                    enc_split = 1'b1;
                end
            end
            KIND_BL: begin
                enc_word  = {3'b000, value_i[13:1]};
                enc_legal = ~value_i[0] && (value_i[15:13] == {3{value_i[13]}});
            end
            KIND_CB: begin
                enc_word  = {3'b001, cond_i, value_i[10:1]};
                enc_legal = ~value_i[0] && (value_i[15:10] == {6{value_i[10]}});
            end
            KIND_LDR: begin
                enc_word  = {2'b10, value_i[6:0], byteOp_i, regAdrB_i, regAdrA_i};
                enc_legal = (value_i[15:6] == {10{value_i[6]}});
            end
            KIND_STR: begin
                enc_word  = {2'b11, value_i[6:0], byteOp_i, regAdrB_i, regAdrA_i};
                enc_legal = (value_i[15:6] == {10{value_i[6]}});
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // Two free slots are kept so a split immediate can always land both words.
    assign reqReady_o = ~arst_i && (state_q == StIdle) &&
                        (level_q <= LVL_W'(DEPTH - 2));
    assign accept     = reqValid_i && reqReady_o;

    always_comb begin
        state_d   = state_q;
        movh_d    = movh_q;
        err_d     = 1'b0;
        push      = 1'b0;
        push_word = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (enc_legal) begin
                        push      = 1'b1;
                        push_word = enc_word;
                        if (enc_split) begin
                            movh_d  = enc_movh;
                            state_d = StHigh;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHigh: begin
                push      = 1'b1;
                push_word = movh_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= StIdle;
            movh_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            movh_q  <= movh_d;
            err_q   <= err_d;
        end
    end

    assign instValid_o = (level_q != '0);
    assign pop         = instValid_o && instReady_i;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign inst_o  = instValid_o ? mem_q[rd_ptr_q] : '0;
    assign err_o   = err_q;
    assign level_o = level_q;

endmodule

// File: tb/tb_xm_inst_encoder.sv
// Self-checking bench for xm_inst_encoder: vector table plus handshake corner sequences,
// with a queue of expected instruction words checked as the FIFO head is popped.
module tb_xm_inst_encoder;

    logic        clk;
    logic        arst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [3:0]  alu_op;
    logic        const_sel;
    logic        byte_op;
    logic [2:0]  reg_a;
    logic [2:0]  reg_b;
    logic [2:0]  cond;
    logic [15:0] value;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        err;
    logic [2:0]  level;

    xm_inst_encoder #(
        .WORD  (16),
        .DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .reqValid_i  (req_valid),
        .reqReady_o  (req_ready),
        .reqKind_i   (req_kind),
        .aluOp_i     (alu_op),
        .constSel_i  (const_sel),
        .byteOp_i    (byte_op),
        .regAdrA_i   (reg_a),
        .regAdrB_i   (reg_b),
        .cond_i      (cond),
        .value_i     (value),
        .inst_o      (inst),
        .instValid_o (inst_valid),
        .instReady_i (inst_ready),
        .err_o       (err),
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  op;
        logic        cs;
        logic        bo;
        logic [2:0]  b;
        logic [2:0]  a;
        logic [2:0]  cd;
        logic [15:0] val;
        logic        e;
        logic [1:0]  nw;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    int          n_vec;
    int          n_fail;
    logic        last_acc;

    function automatic vec_t mk(input logic [2:0] k, input logic [3:0] op, input logic cs,
                                input logic bo, input logic [2:0] b, input logic [2:0] a,
                                input logic [2:0] cd, input logic [15:0] val, input logic e,
                                input logic [1:0] nw, input logic [15:0] w0,
                                input logic [15:0] w1);
        vec_t v;
        v.kind = k; v.op = op; v.cs = cs; v.bo = bo; v.b = b; v.a = a; v.cd = cd;
        v.val = val; v.e = e; v.nw = nw; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called right after a falling edge; samples settled signals before the next
    // rising edge and scores any word popped there.
    task automatic tick();
        logic [15:0] w;
        #3;
        last_acc = req_valid && req_ready;
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none at %0t", inst, $time);
            end else begin
                w = exp_q.pop_front();
                chk("fifo_word", {16'h0, inst}, {16'h0, w});
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((level != 0 || exp_q.size() != 0) && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_level", {29'h0, level}, 32'h0);
    endtask

    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!req_ready) chk("ready_wait", {31'h0, req_ready}, 32'h1);
        req_kind  = v.kind;
        alu_op    = v.op;
        const_sel = v.cs;
        byte_op   = v.bo;
        reg_b     = v.b;
        reg_a     = v.a;
        cond      = v.cd;
        value     = v.val;
        req_valid = 1'b1;
        if (!v.e) begin
            exp_q.push_back(v.w0);
            if (v.nw == 2'd2) exp_q.push_back(v.w1);
        end
        tick();
        chk("accepted", {31'h0, last_acc}, 32'h1);
        req_valid = 1'b0;
        chk("err_flag", {31'h0, err}, {31'h0, v.e});
        if (v.nw == 2'd2) begin
            chk("ready_in_high", {31'h0, req_ready}, 32'h0);
            tick();
            chk("ready_after_high", {31'h0, req_ready}, 32'h1);
        end
        if (v.e) begin
            chk("err_level", {29'h0, level}, 32'h0);
            tick();
            chk("err_pulse_end", {31'h0, err}, 32'h0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        last_acc = 1'b0;
        arst = 1'b1;
        req_valid = 1'b0;
        req_kind = '0; alu_op = '0; const_sel = 1'b0; byte_op = 1'b0;
        reg_a = '0; reg_b = '0; cond = '0; value = '0;
        inst_ready = 1'b1;

        //       kind  op     cs    bo    B     A     cond  value     err  nw   w0        w1
        vecs.push_back(mk(3'd0, 4'h0, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0, 2'd1, 16'h400A, 16'h0));
        vecs.push_back(mk(3'd0, 4'hC, 1'b1, 1'b1, 3'd5, 3'd6, 3'd0, 16'h0000, 1'b0, 2'd1, 16'h4CEE, 16'h0));
        vecs.push_back(mk(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 16'h1234, 1'b0, 2'd2, 16'h61A3, 16'h7893));
        vecs.push_back(mk(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFF80, 1'b0, 2'd1, 16'h7400, 16'h0));
        vecs.push_back(mk(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd7, 3'd0, 16'h0055, 1'b0, 2'd1, 16'h6AAF, 16'h0));
        vecs.push_back(mk(3'd1, 4'h0, 1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 16'h0100, 1'b0, 2'd2, 16'h6005, 16'h780D));
        vecs.push_back(mk(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFFC, 1'b0, 2'd1, 16'h1FFE, 16'h0));
        vecs.push_back(mk(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h1FFE, 1'b0, 2'd1, 16'h0FFF, 16'h0));
        vecs.push_back(mk(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'hE000, 1'b0, 2'd1, 16'h1000, 16'h0));
        vecs.push_back(mk(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h2000, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd2, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0003, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd3, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 16'h0006, 1'b0, 2'd1, 16'h2403, 16'h0));
        vecs.push_back(mk(3'd3, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 16'hFC00, 1'b0, 2'd1, 16'h3E00, 16'h0));
        vecs.push_back(mk(3'd3, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 16'h0005, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd3, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd1, 16'h0400, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd4, 4'h0, 1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 16'hFFFF, 1'b0, 2'd1, 16'hBF91, 16'h0));
        vecs.push_back(mk(3'd5, 4'h0, 1'b0, 1'b1, 3'd3, 3'd4, 3'd0, 16'h003F, 1'b0, 2'd1, 16'hDFDC, 16'h0));
        vecs.push_back(mk(3'd5, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0040, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd4, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'hFFBF, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd7, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 2'd0, 16'h0,    16'h0));
        vecs.push_back(mk(3'd6, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 2'd0, 16'h0,    16'h0));

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", {16'h0, inst}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_level", {29'h0, level}, 32'h0);
        arst = 1'b0;
        tick();
        chk("idle_ready", {31'h0, req_ready}, 32'h1);

        foreach (vecs[i]) begin
            drain();
            send(vecs[i]);
        end
        drain();

        // Backpressure: level 2 still accepts, level 3 blocks; then pop+push holds level.
        inst_ready = 1'b0;
        send(mk(3'd0, 4'h1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'd1, 16'h4100, 16'h0));
        send(mk(3'd0, 4'h2, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'd1, 16'h4200, 16'h0));
        chk("bp_level2", {29'h0, level}, 32'h2);
        chk("bp_ready_at2", {31'h0, req_ready}, 32'h1);
        send(mk(3'd0, 4'h3, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'd1, 16'h4300, 16'h0));
        chk("bp_level3", {29'h0, level}, 32'h3);
        chk("bp_ready_at3", {31'h0, req_ready}, 32'h0);
        tick();
        chk("bp_hold_level", {29'h0, level}, 32'h3);
        inst_ready = 1'b1;
        tick();
        chk("bp_pop_level", {29'h0, level}, 32'h2);
        chk("bp_ready_again", {31'h0, req_ready}, 32'h1);
        send(mk(3'd0, 4'h4, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 2'd1, 16'h4400, 16'h0));
        chk("bp_pushpop_level", {29'h0, level}, 32'h2);
        drain();

        // Reset while the MOVH is pending: everything is dropped.
        req_kind  = 3'd1;
        reg_a     = 3'd3;
        value     = 16'h1234;
        req_valid = 1'b1;
        tick();
        chk("rh_accepted", {31'h0, last_acc}, 32'h1);
        req_valid = 1'b0;
        chk("rh_movl_valid", {31'h0, inst_valid}, 32'h1);
        chk("rh_movl_word", {16'h0, inst}, 32'h61A3);
        chk("rh_in_high", {31'h0, req_ready}, 32'h0);
        inst_ready = 1'b0;
        arst = 1'b1;
        #1;
        chk("rh_valid", {31'h0, inst_valid}, 32'h0);
        chk("rh_level", {29'h0, level}, 32'h0);
        chk("rh_inst", {16'h0, inst}, 32'h0);
        chk("rh_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        inst_ready = 1'b1;
        tick();
        arst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rh_no_movh_valid", {31'h0, inst_valid}, 32'h0);
        chk("rh_no_movh_level", {29'h0, level}, 32'h0);
        chk("rh_ready_back", {31'h0, req_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
